// File: rtl/instruction_aligner_pkg.sv
// Shared decode definitions for the fetch-side aligner and the decoder.
// Contents:
//   parcel_t       16-bit instruction parcel (one halfword)
//   count_t        parcel buffer occupancy, 0..ParcelDepth
//   ParcelDepth    number of halfword entries in the parcel buffer
//   is_compressed  16/32-bit select from the low two bits of a parcel
package instruction_aligner_pkg;

  localparam int unsigned ParcelDepth = 4;
  localparam int unsigned CountWidth  = 3;

  typedef logic [15:0]           parcel_t;
  typedef logic [CountWidth-1:0] count_t;

  // Any parcel whose low two bits are not 2'b11 is a complete 16-bit instruction.
  function automatic logic is_compressed(parcel_t parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instruction_parcel_buffer.sv
// Four-entry halfword shift queue feeding the instruction aligner.
// Ports:
//   Clk, Reset      clock and synchronous active-high reset
//   Flush           empty the queue (takes priority over pop/push)
//   PopNum          parcels removed from the head this cycle (0, 1 or 2)
//   PushNum         parcels appended this cycle (0, 1 or 2)
//   PushLo, PushHi  parcels to append, PushLo first
//   Count           current occupancy
//   Head0, Head1    the two oldest parcels
module instruction_parcel_buffer
  import instruction_aligner_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Flush,
  input  logic [1:0] PopNum,
  input  logic [1:0] PushNum,
  input  parcel_t    PushLo,
  input  parcel_t    PushHi,
  output count_t     Count,
  output parcel_t    Head0,
  output parcel_t    Head1
);

  parcel_t bufQ [ParcelDepth];
  parcel_t bufD [ParcelDepth];
  count_t  countQ;
  count_t  countD;
  count_t  base;
  count_t  baseNext;

  // Shift out popped parcels first, then append behind what remains.
  always_comb begin
    case (PopNum)
      2'd1:    bufD = '{bufQ[1], bufQ[2], bufQ[3], 16'h0000};
      2'd2:    bufD = '{bufQ[2], bufQ[3], 16'h0000, 16'h0000};
      default: bufD = bufQ;
    endcase
    base     = countQ - count_t'(PopNum);
    baseNext = base + count_t'(1);
    if (PushNum != 2'd0 && base < count_t'(ParcelDepth)) begin
      bufD[base[1:0]] = PushLo;
    end
    if (PushNum == 2'd2 && baseNext < count_t'(ParcelDepth)) begin
      bufD[baseNext[1:0]] = PushHi;
    end
    countD = base + count_t'(PushNum);
    if (Flush) begin
      countD = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      countQ <= '0;
      bufQ   <= '{default: '0};
    end else begin
      countQ <= countD;
      bufQ   <= bufD;
    end
  end

  assign Count = countQ;
  assign Head0 = bufQ[0];
  assign Head1 = bufQ[1];

endmodule

// File: rtl/instruction_aligner.sv
// Fetch-side producer for the decoder's 32-bit instruction input.
// Issues word-aligned fetches, buffers returned halfword parcels and presents one
// aligned instruction (16-bit zero-extended or 32-bit, possibly straddling words)
// per InstrValid/InstrReady handshake. Handles redirects to halfword targets.
// Ports:
//   Clk, Reset                         clock, synchronous active-high reset
//   FetchReq/FetchAddr/FetchAck        word fetch request, held until acked
//   FetchRValid/FetchRData             read response, little-endian parcels
//   RedirectValid/RedirectPC           PC redirect, bit 0 ignored
//   InstrValid/InstrReady              instruction handshake to the decoder
//   InstrOut/InstrPC/InstrCompressed   instruction, its PC and 16-bit flag
module instruction_aligner
  import instruction_aligner_pkg::*;
#(
  parameter logic [31:0] ResetVector = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        FetchReq,
  output logic [31:0] FetchAddr,
  input  logic        FetchAck,
  input  logic        FetchRValid,
  input  logic [31:0] FetchRData,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic        InstrCompressed
);

  logic        fetchReqQ, fetchReqD;
  logic [31:0] fetchAddrQ, fetchAddrD;
  logic [31:0] fetchPcQ, fetchPcD;
  logic        outstandingQ, outstandingD;
  logic        discardQ, discardD;
  logic        skipLowQ, skipLowD;
  logic [31:0] instrPcQ, instrPcD;

  count_t     count;
  parcel_t    head0;
  parcel_t    head1;
  parcel_t    pushLo;
  logic [1:0] popNum;
  logic [1:0] pushNum;
  logic       compressed;
  logic       instrValidInt;
  logic       fire;
  logic       accept;
  logic       issue;

  logic unusedRedirectPc0;
  assign unusedRedirectPc0 = RedirectPC[0];

  instruction_parcel_buffer u_parcel_buffer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Flush   (RedirectValid),
    .PopNum  (popNum),
    .PushNum (pushNum),
    .PushLo  (pushLo),
    .PushHi  (FetchRData[31:16]),
    .Count   (count),
    .Head0   (head0),
    .Head1   (head1)
  );

  assign compressed    = is_compressed(head0);
  assign instrValidInt = (count >= count_t'(1) && compressed) ||
                         (count >= count_t'(2) && !compressed);
  assign fire          = instrValidInt && InstrReady && !RedirectValid;

  // A redirect flushes the queue, so it also suppresses any pop or append.
  assign accept  = FetchRValid && !discardQ && !RedirectValid;
  assign popNum  = fire ? (compressed ? 2'd1 : 2'd2) : 2'd0;
  assign pushNum = accept ? (skipLowQ ? 2'd1 : 2'd2) : 2'd0;
  assign pushLo  = skipLowQ ? FetchRData[31:16] : FetchRData[15:0];

  // Room for a full word is guaranteed because the queue only drains while in flight.
  assign issue = !outstandingQ && !RedirectValid && count <= count_t'(2);

  always_comb begin
    fetchReqD    = fetchReqQ;
    fetchAddrD   = fetchAddrQ;
    fetchPcD     = fetchPcQ;
    outstandingD = outstandingQ;
    discardD     = discardQ;
    skipLowD     = skipLowQ;
    instrPcD     = instrPcQ;

    if (fetchReqQ && FetchAck) begin
      fetchReqD = 1'b0;
    end
    if (FetchRValid) begin
      outstandingD = 1'b0;
      discardD     = 1'b0;
    end
    if (accept && skipLowQ) begin
      skipLowD = 1'b0;
    end
    // FetchPC advances when the address is latched; FetchAddr holds the request
    // stable, and a later redirect can overwrite FetchPC without losing its target.
    if (issue) begin
      fetchReqD    = 1'b1;
      outstandingD = 1'b1;
      fetchAddrD   = fetchPcQ;
      fetchPcD     = fetchPcQ + 32'd4;
    end
    if (fire) begin
      instrPcD = instrPcQ + (compressed ? 32'd2 : 32'd4);
    end
    if (RedirectValid) begin
      instrPcD = {RedirectPC[31:1], 1'b0};
      fetchPcD = {RedirectPC[31:2], 2'b00};
      skipLowD = RedirectPC[1];
      // A response landing this very cycle is dropped by the flush instead.
      if (outstandingQ && !FetchRValid) begin
        discardD = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetchReqQ    <= 1'b0;
      fetchAddrQ   <= {ResetVector[31:2], 2'b00};
      fetchPcQ     <= {ResetVector[31:2], 2'b00};
      outstandingQ <= 1'b0;
      discardQ     <= 1'b0;
      skipLowQ     <= ResetVector[1];
      instrPcQ     <= ResetVector;
    end else begin
      fetchReqQ    <= fetchReqD;
      fetchAddrQ   <= fetchAddrD;
      fetchPcQ     <= fetchPcD;
      outstandingQ <= outstandingD;
      discardQ     <= discardD;
      skipLowQ     <= skipLowD;
      instrPcQ     <= instrPcD;
    end
  end

  assign FetchReq        = fetchReqQ;
  assign FetchAddr       = fetchAddrQ;
  assign InstrValid      = instrValidInt;
  assign InstrPC         = instrPcQ;
  assign InstrCompressed = instrValidInt && compressed;

  always_comb begin
    InstrOut = '0;
    if (instrValidInt) begin
      InstrOut = compressed ? {16'h0000, head0} : {head1, head0};
    end
  end

endmodule

// File: tb/tb_instruction_aligner.sv
// Directed bench for instruction_aligner: a behavioural word memory with adjustable
// latency, a queue of hand-computed expected instructions, and a monitor that
// compares every accepted instruction against the head of that queue.
module tb_instruction_aligner;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic        FetchAck;
  logic        FetchRValid = 1'b0;
  logic [31:0] FetchRData = '0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrCompressed;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        expQ [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [256];
  int          memLat = 1;
  logic        memPend = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = '0;

  instruction_aligner #(
    .ResetVector (32'h0000_0000)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .FetchReq        (FetchReq),
    .FetchAddr       (FetchAddr),
    .FetchAck        (FetchAck),
    .FetchRValid     (FetchRValid),
    .FetchRData      (FetchRData),
    .RedirectValid   (RedirectValid),
    .RedirectPC      (RedirectPC),
    .InstrValid      (InstrValid),
    .InstrReady      (InstrReady),
    .InstrOut        (InstrOut),
    .InstrPC         (InstrPC),
    .InstrCompressed (InstrCompressed)
  );

  always #5 Clk = ~Clk;

  // Memory accepts every request immediately; data follows memLat cycles later.
  assign FetchAck = FetchReq;

  always @(posedge Clk) begin
    if (Reset) begin
      memPend     <= 1'b0;
      memCnt      <= 0;
      FetchRValid <= 1'b0;
    end else begin
      FetchRValid <= 1'b0;
      if (memPend) begin
        memCnt <= memCnt - 1;
        if (memCnt == 1) begin
          FetchRValid <= 1'b1;
          FetchRData  <= mem[memAddr[9:2]];
          memPend     <= 1'b0;
        end
      end
      if (FetchReq && FetchAck) begin
        if (memLat <= 1) begin
          FetchRValid <= 1'b1;
          FetchRData  <= mem[FetchAddr[9:2]];
        end else begin
          memPend <= 1'b1;
          memCnt  <= memLat - 1;
          memAddr <= FetchAddr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic expectInstr(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.comp  = comp;
    expQ.push_back(e);
  endtask

  // Monitor: the handshake completes on the following rising edge.
  always @(negedge Clk) begin
    if (!Reset && InstrValid && InstrReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual=%08h@%08h required=none", InstrOut, InstrPC);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("instr_out", InstrOut, e.instr);
        check("instr_pc", InstrPC, e.pc);
        check("instr_compressed", {31'b0, InstrCompressed}, {31'b0, e.comp});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    RedirectValid = 1'b1;
    RedirectPC    = pc;
    idle(1);
    RedirectValid = 1'b0;
  endtask

  // Let the decoder accept until every expected instruction is seen, then stall it.
  task automatic drainWait(input string name, input int limit);
    int n = 0;
    while (expQ.size() != 0 && n < limit) begin
      idle(1);
      n++;
    end
    InstrReady = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic waitFetch(input string name, input logic [31:0] reqAddr, input int limit);
    int n = 0;
    while (!FetchReq && n < limit) begin
      idle(1);
      n++;
    end
    if (!FetchReq) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_request required=%08h", name, reqAddr);
    end else begin
      check(name, FetchAddr, reqAddr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 32'h0001_0093;
    mem[8'h01] = 32'h0000_4501;
    mem[8'h40] = 32'h4585_FFFF;
    mem[8'h41] = 32'h0001_0113;
    mem[8'h60] = 32'hDEAD_BEEF;
    mem[8'h70] = 32'h0001_0213;
    mem[8'h71] = 32'h4605_4505;
    mem[8'h90] = 32'h4705_4605;
    mem[8'h91] = 32'h0001_0313;
    mem[8'h92] = 32'h4905_4805;
    mem[8'hB0] = 32'h4A05_1111;
    mem[8'hB1] = 32'h4C05_4B05;

    // Reset state, first-fetch latency, 32-bit then compressed instructions.
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rst_instr_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_fetch_req", {31'b0, FetchReq}, 32'd0);
    check("rst_fetch_addr", FetchAddr, 32'h0000_0000);
    check("rst_instr_pc", InstrPC, 32'h0000_0000);
    check("rst_instr_out", InstrOut, 32'h0000_0000);
    check("rst_instr_compressed", {31'b0, InstrCompressed}, 32'd0);
    expectInstr(32'h0001_0093, 32'h0000_0000, 1'b0);
    expectInstr(32'h0000_4501, 32'h0000_0004, 1'b1);
    expectInstr(32'h0000_0000, 32'h0000_0006, 1'b1);
    InstrReady = 1'b1;
    n = 0;
    while (!(FetchReq && FetchAck) && n < 10) begin
      idle(1);
      n++;
    end
    check("first_fetch_addr", FetchAddr, 32'h0000_0000);
    idle(1);
    check("latency_n1_valid", {31'b0, InstrValid}, 32'd0);
    idle(1);
    check("latency_n2_valid", {31'b0, InstrValid}, 32'd1);
    drainWait("basic", 60);
    idle(8);

    // Redirect to a halfword target: low halfword of the word is dropped.
    expectInstr(32'h0000_4585, 32'h0000_0102, 1'b1);
    expectInstr(32'h0001_0113, 32'h0000_0104, 1'b0);
    doRedirect(32'h0000_0102);
    check("redirect_bubble", {31'b0, InstrValid}, 32'd0);
    check("redirect_instr_pc", InstrPC, 32'h0000_0102);
    waitFetch("redirect_fetch_addr", 32'h0000_0100, 10);
    InstrReady = 1'b1;
    drainWait("halfword_redirect", 60);
    idle(8);

    // Redirect while an acked request is still waiting for its data.
    memLat = 3;
    doRedirect(32'h0000_0180);
    n = 0;
    while (!(FetchReq && FetchAck) && n < 10) begin
      idle(1);
      n++;
    end
    idle(1);
    expectInstr(32'h0001_0213, 32'h0000_01C0, 1'b0);
    expectInstr(32'h0000_4505, 32'h0000_01C4, 1'b1);
    expectInstr(32'h0000_4605, 32'h0000_01C6, 1'b1);
    doRedirect(32'h0000_01C0);
    waitFetch("stale_next_fetch_addr", 32'h0000_01C0, 20);
    InstrReady = 1'b1;
    drainWait("stale_discard", 80);
    memLat = 1;
    idle(8);

    // Decoder stalled: buffer fills, fetching stops, nothing is lost.
    expectInstr(32'h0000_4605, 32'h0000_0240, 1'b1);
    expectInstr(32'h0000_4705, 32'h0000_0242, 1'b1);
    expectInstr(32'h0001_0313, 32'h0000_0244, 1'b0);
    expectInstr(32'h0000_4805, 32'h0000_0248, 1'b1);
    expectInstr(32'h0000_4905, 32'h0000_024A, 1'b1);
    doRedirect(32'h0000_0240);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (i >= 5) check("stall_fetch_req", {31'b0, FetchReq}, 32'd0);
    end
    check("stall_head_valid", {31'b0, InstrValid}, 32'd1);
    InstrReady = 1'b1;
    drainWait("stall_drain", 60);
    idle(8);

    // Reset with a parcel buffered and a request in flight.
    memLat = 4;
    doRedirect(32'h0000_02C2);
    n = 0;
    while (!(FetchReq && FetchAddr == 32'h0000_02C4) && n < 40) begin
      idle(1);
      n++;
    end
    check("mid_fetch_addr", FetchAddr, 32'h0000_02C4);
    idle(1);
    check("pre_reset_valid", {31'b0, InstrValid}, 32'd1);
    mem[8'h00] = 32'h0093_4505;
    mem[8'h01] = 32'h1234_0001;
    memLat = 1;
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    check("midrst_instr_valid", {31'b0, InstrValid}, 32'd0);
    check("midrst_instr_pc", InstrPC, 32'h0000_0000);
    check("midrst_fetch_req", {31'b0, FetchReq}, 32'd0);
    check("midrst_fetch_addr", FetchAddr, 32'h0000_0000);

    // After reset: compressed, straddling 32-bit, compressed.
    expectInstr(32'h0000_4505, 32'h0000_0000, 1'b1);
    expectInstr(32'h0001_0093, 32'h0000_0002, 1'b0);
    expectInstr(32'h0000_1234, 32'h0000_0006, 1'b1);
    InstrReady = 1'b1;
    drainWait("straddle", 60);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
